// File: rtl/kronos_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : kronos_hazard_ctrl
//  Description : Register scoreboard and ID-stage stall controller. Tracks
//                architectural registers with a write in flight between ID
//                issue and WB retire, and stalls ID on RAW/WAW hazards or
//                when the in-flight write budget is used up.
//  Options     : KRONOS_HCU_WB_BYPASS_EN - a register retiring in the current
//                cycle is treated as not busy (ID forwards the WB data), and
//                the slot it frees counts toward the write budget at once.
//  Revision    : 1.0 - initial release
// ============================================================================
module kronos_hazard_ctrl #(
    parameter int MAX_INFLIGHT = 3,
    parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_vld,
    input  logic             ex_rdy,
    input  logic [4:0]       id_rs1,
    input  logic             id_rs1_use,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs2_use,
    input  logic [4:0]       id_rd,
    input  logic             id_rd_write,
    input  logic             regwr_en,
    input  logic [4:0]       regwr_sel,
    input  logic             flush,
    output logic             stall,
    output logic             issue,
    output logic [31:0]      pending,
    output logic [CNT_W-1:0] inflight,
    output logic             sb_err
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    logic [31:0]      pend_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    logic [31:0]      pend_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [31:0]      busy_vec;
    logic [31:0]      retire_onehot;
    logic             retire_hit;
    logic             retire_ok;
    logic             rd_real;
    logic             raw;
    logic             waw;
    logic             full;
    logic             set_en;
    logic             err_set;

    // Retire-side decode: a real retire targets a non-zero register, and it
    // is legal only if that register is actually pending.
    always_comb begin
        retire_hit    = regwr_en & (regwr_sel != 5'd0);
        retire_onehot = retire_hit ? (32'd1 << regwr_sel) : 32'd0;
        retire_ok     = retire_hit & pend_q[regwr_sel];
    end

    // Hazard detection and issue decision; x0 is never busy because
    // pend_q[0] is held at zero.
    always_comb begin
`ifdef KRONOS_HCU_WB_BYPASS_EN
        busy_vec = pend_q & ~retire_onehot;
`else
        busy_vec = pend_q;
`endif
        rd_real = id_rd_write & (id_rd != 5'd0);
        raw     = (id_rs1_use & busy_vec[id_rs1]) | (id_rs2_use & busy_vec[id_rs2]);
        waw     = rd_real & busy_vec[id_rd];
`ifdef KRONOS_HCU_WB_BYPASS_EN
        full    = rd_real & (cnt_q == MAX_CNT) & ~retire_ok;
`else
        full    = rd_real & (cnt_q == MAX_CNT);
`endif
        stall   = id_vld & (raw | waw | full);
        issue   = id_vld & ex_rdy & ~stall;
        set_en  = issue & rd_real;
    end

    // Next scoreboard and counter values; a same-register set and clear
    // leaves the bit set, and the count only moves on an unbalanced update.
    always_comb begin
        pend_nxt = pend_q & ~retire_onehot;
        if (set_en) begin
            pend_nxt[id_rd] = 1'b1;
        end
        pend_nxt[0] = 1'b0;

        cnt_nxt = cnt_q;
        err_set = retire_hit & ~pend_q[regwr_sel];
        if (set_en && !retire_ok) begin
            if (cnt_q == MAX_CNT) begin
                err_set = 1'b1;
            end else begin
                cnt_nxt = cnt_q + ONE_CNT;
            end
        end else if (retire_ok && !set_en) begin
            if (cnt_q == '0) begin
                err_set = 1'b1;
            end else begin
                cnt_nxt = cnt_q - ONE_CNT;
            end
        end
    end

    // State registers; flush wipes the scoreboard and suppresses the error
    // check on the flushing instruction's own retire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= 32'd0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else if (flush) begin
            pend_q <= 32'd0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_nxt;
            cnt_q  <= cnt_nxt;
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    assign pending  = pend_q;
    assign inflight = cnt_q;
    assign sb_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_kronos_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_kronos_hazard_ctrl
//  Description : Self-checking bench for kronos_hazard_ctrl. A set-of-busy-
//                registers model predicts stall/issue/pending/inflight/sb_err
//                every cycle; directed scenarios pin the model with literals.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_kronos_hazard_ctrl;

    localparam int MAXF = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_vld, ex_rdy;
    logic [4:0]  id_rs1, id_rs2, id_rd, regwr_sel;
    logic        id_rs1_use, id_rs2_use, id_rd_write, regwr_en, flush;
    logic        stall, issue, sb_err;
    logic [31:0] pending;
    logic [1:0]  inflight;

    int checks   = 0;
    int failures = 0;

    bit [31:0] m_pend;
    bit        m_err;

    kronos_hazard_ctrl #(.MAX_INFLIGHT(MAXF)) dut (
        .clk(clk), .rst(rst),
        .id_vld(id_vld), .ex_rdy(ex_rdy),
        .id_rs1(id_rs1), .id_rs1_use(id_rs1_use),
        .id_rs2(id_rs2), .id_rs2_use(id_rs2_use),
        .id_rd(id_rd), .id_rd_write(id_rd_write),
        .regwr_en(regwr_en), .regwr_sel(regwr_sel),
        .flush(flush),
        .stall(stall), .issue(issue), .pending(pending),
        .inflight(inflight), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit m_busy(input logic [4:0] r);
        bit b;
        b = (r != 5'd0) && m_pend[r];
`ifdef KRONOS_HCU_WB_BYPASS_EN
        if (regwr_en && regwr_sel == r) b = 1'b0;
`endif
        return b;
    endfunction

    function automatic bit m_stall();
        int  cnt;
        bit  full;
        cnt = $countones(m_pend);
`ifdef KRONOS_HCU_WB_BYPASS_EN
        if (regwr_en && regwr_sel != 5'd0 && m_pend[regwr_sel]) cnt = cnt - 1;
`endif
        full = id_rd_write && id_rd != 5'd0 && cnt == MAXF;
        return id_vld && ((id_rs1_use && m_busy(id_rs1)) || (id_rs2_use && m_busy(id_rs2)) ||
                          (id_rd_write && m_busy(id_rd)) || full);
    endfunction

    function automatic bit m_issue();
        return id_vld && ex_rdy && !m_stall();
    endfunction

    function automatic bit [31:0] m_next();
        bit [31:0] p;
        p = m_pend;
        if (regwr_en && regwr_sel != 5'd0) p[regwr_sel] = 1'b0;
        if (m_issue() && id_rd_write && id_rd != 5'd0) p[id_rd] = 1'b1;
        return p;
    endfunction

    // Model state advance on each clock edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend <= 32'd0;
            m_err  <= 1'b0;
        end else if (flush) begin
            m_pend <= 32'd0;
        end else begin
            if (regwr_en && regwr_sel != 5'd0 && !m_pend[regwr_sel]) m_err <= 1'b1;
            m_pend <= m_next();
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("cmp_stall",    {31'd0, stall},   {31'd0, m_stall()});
            chk("cmp_issue",    {31'd0, issue},   {31'd0, m_issue()});
            chk("cmp_pending",  pending,          m_pend);
            chk("cmp_inflight", {30'd0, inflight}, 32'($countones(m_pend)));
            chk("cmp_sb_err",   {31'd0, sb_err},  {31'd0, m_err});
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic er,
                         input logic [4:0] r1, input logic u1,
                         input logic [4:0] r2, input logic u2,
                         input logic [4:0] rd, input logic w,
                         input logic re, input logic [4:0] rs, input logic fl);
        id_vld = v;  ex_rdy = er;
        id_rs1 = r1; id_rs1_use = u1;
        id_rs2 = r2; id_rs2_use = u2;
        id_rd  = rd; id_rd_write = w;
        regwr_en = re; regwr_sel = rs; flush = fl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_pending",  pending, 32'd0);
        chk("rst_inflight", {30'd0, inflight}, 32'd0);
        chk("rst_sb_err",   {31'd0, sb_err}, 32'd0);
        chk("rst_stall",    {31'd0, stall}, 32'd0);
        tick();

        // ADD x5, x1, x2
        drive(1, 1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0);
        @(negedge clk);
        chk("add_issue", {31'd0, issue}, 32'd1);
        chk("add_stall", {31'd0, stall}, 32'd0);
        tick();
        idle();
        chk("add_pending",  pending, 32'h0000_0020);
        chk("add_inflight", {30'd0, inflight}, 32'd1);

        // ADDI x6, x5 : RAW on x5
        drive(1, 1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0, 0);
        @(negedge clk);
        chk("raw_stall0", {31'd0, stall}, 32'd1);
        chk("raw_issue0", {31'd0, issue}, 32'd0);
        tick();
        @(negedge clk);
        chk("raw_stall1", {31'd0, stall}, 32'd1);
        tick();
        drive(1, 1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 1, 5'd5, 0);
        @(negedge clk);
`ifdef KRONOS_HCU_WB_BYPASS_EN
        chk("raw_retire_stall", {31'd0, stall}, 32'd0);
        chk("raw_retire_issue", {31'd0, issue}, 32'd1);
        tick();
        idle();
`else
        chk("raw_retire_stall", {31'd0, stall}, 32'd1);
        chk("raw_retire_issue", {31'd0, issue}, 32'd0);
        tick();
        drive(1, 1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0, 0);
        @(negedge clk);
        chk("raw_after_stall", {31'd0, stall}, 32'd0);
        chk("raw_after_issue", {31'd0, issue}, 32'd1);
        tick();
        idle();
`endif
        chk("raw_pending",  pending, 32'h0000_0040);
        chk("raw_inflight", {30'd0, inflight}, 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd6, 0);
        tick();
        idle();
        chk("x6_retired", pending, 32'd0);

        // Fill the budget with x1..x3, then try x4
        for (int i = 1; i <= 3; i++) begin
            drive(1, 1, 0, 0, 0, 0, 5'(i), 1, 0, 0, 0);
            tick();
        end
        idle();
        chk("full_pending",  pending, 32'h0000_000E);
        chk("full_inflight", {30'd0, inflight}, 32'd3);
        drive(1, 1, 0, 0, 0, 0, 5'd4, 1, 0, 0, 0);
        @(negedge clk);
        chk("full_stall", {31'd0, stall}, 32'd1);
        tick();
        drive(1, 1, 0, 0, 0, 0, 5'd4, 1, 1, 5'd1, 0);
        @(negedge clk);
`ifdef KRONOS_HCU_WB_BYPASS_EN
        chk("full_retire_issue", {31'd0, issue}, 32'd1);
        tick();
`else
        chk("full_retire_issue", {31'd0, issue}, 32'd0);
        tick();
        drive(1, 1, 0, 0, 0, 0, 5'd4, 1, 0, 0, 0);
        @(negedge clk);
        chk("full_after_issue", {31'd0, issue}, 32'd1);
        tick();
`endif
        idle();
        chk("full_end_pending",  pending, 32'h0000_001C);
        chk("full_end_inflight", {30'd0, inflight}, 32'd3);
        for (int i = 2; i <= 4; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'(i), 0);
            tick();
        end
        idle();
        chk("drain_pending",  pending, 32'd0);
        chk("drain_inflight", {30'd0, inflight}, 32'd0);

        // EX not ready: no stall, no issue, nothing recorded
        drive(1, 0, 0, 0, 0, 0, 5'd9, 1, 0, 0, 0);
        @(negedge clk);
        chk("exrdy_issue", {31'd0, issue}, 32'd0);
        chk("exrdy_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("exrdy_pending", pending, 32'd0);

        // x0 everywhere
        drive(1, 1, 5'd0, 1, 5'd0, 1, 5'd0, 1, 0, 0, 0);
        @(negedge clk);
        chk("x0_stall", {31'd0, stall}, 32'd0);
        chk("x0_issue", {31'd0, issue}, 32'd1);
        tick();
        idle();
        chk("x0_pending",  pending, 32'd0);
        chk("x0_inflight", {30'd0, inflight}, 32'd0);

        // x7, x8 pending, then flush with retire of x7
        drive(1, 1, 0, 0, 0, 0, 5'd7, 1, 0, 0, 0);
        tick();
        drive(1, 1, 0, 0, 0, 0, 5'd8, 1, 0, 0, 0);
        tick();
        idle();
        chk("pre_flush_pending", pending, 32'h0000_0180);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 1);
        tick();
        idle();
        chk("flush_pending",  pending, 32'd0);
        chk("flush_inflight", {30'd0, inflight}, 32'd0);
        chk("flush_sb_err",   {31'd0, sb_err}, 32'd0);

        // Retire of a non-pending register
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd9, 0);
        tick();
        idle();
        chk("err_set",      {31'd0, sb_err}, 32'd1);
        chk("err_inflight", {30'd0, inflight}, 32'd0);
        repeat (3) tick();
        chk("err_sticky", {31'd0, sb_err}, 32'd1);

        // Asynchronous reset mid-operation
        drive(1, 1, 0, 0, 0, 0, 5'd10, 1, 0, 0, 0);
        tick();
        idle();
        chk("pre_rst_pending", pending, 32'h0000_0400);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_pending", pending, 32'd0);
        chk("async_rst_sb_err",  {31'd0, sb_err}, 32'd0);
        tick();
        rst = 1'b0;
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
